// File: rtl/train_drive.sv
// train_drive: ramped PWM motor drive for two trains plus one-at-a-time solenoid pulses for three twin-coil switches.
// Optional feature macro TRAIN_DRIVE_BRAKE_EN: command 11 forces duty to 0 on the next edge instead of ramping down.
module train_drive #(
  parameter int PWM_BITS  = 8,
  parameter int MAX_DUTY  = 200,
  parameter int RAMP_DIV  = 16,
  parameter int PULSE_LEN = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dira,
  input  logic [1:0] dirb,
  input  logic [2:0] sw,
  output logic       pwma,
  output logic       pwmb,
  output logic       fwda,
  output logic       fwdb,
  output logic [2:0] sw_norm,
  output logic [2:0] sw_div,
  output logic       sw_busy
);
  typedef enum logic {IDLE, PULSE} state_t;
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int PW = PULSE_LEN > 1 ? $clog2(PULSE_LEN) : 1;
  logic [CW-1:0] pre;
  logic tick;
  logic [PWM_BITS-1:0] cnt;
  logic [3:0] cmds;
  logic [1:0] pwm_v, fwd_v;
  assign cmds = {dirb, dira};
  assign tick = pre == CW'(RAMP_DIV - 1);
  assign pwma = pwm_v[0];
  assign pwmb = pwm_v[1];
  assign fwda = fwd_v[0];
  assign fwdb = fwd_v[1];
  // shared ramp prescaler and free-running PWM counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + CW'(1);
      cnt <= cnt + PWM_BITS'(1);
    end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0] cm;
    logic mv, mis, brake, fwd, pwm;
    logic [PWM_BITS-1:0] duty, tgt, ramp;
    assign cm = cmds[2*c +: 2];
    assign pwm_v[c] = pwm;
    assign fwd_v[c] = fwd;
`ifdef TRAIN_DRIVE_BRAKE_EN
    assign brake = cm == 2'b11;
`else
    assign brake = 1'b0;
`endif
    // target selection: a direction mismatch must bleed duty to 0 before polarity may flip
    always_comb begin
      mv = cm == 2'b01 || cm == 2'b10;
      mis = mv && (cm[0] != fwd);
      tgt = mv ? PWM_BITS'(MAX_DUTY) : '0;
      ramp = duty < tgt ? duty + PWM_BITS'(1) : duty > tgt ? duty - PWM_BITS'(1) : duty;
    end
    // per-channel duty ramp, polarity and registered PWM compare
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        duty <= '0;
        fwd <= 1'b1;
        pwm <= 1'b0;
      end else begin
        pwm <= cnt < duty;
        if (brake) duty <= '0;
        else if (tick) duty <= mis ? (duty == '0 ? duty : duty - PWM_BITS'(1)) : ramp;
        if (tick && mis && duty == '0) fwd <= cm[0];
      end
  end
  state_t state, state_d;
  logic [2:0] pend, sw_q, sel;
  logic start, fin;
  logic [PW-1:0] pcnt;
  // pulse engine state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // pick the lowest pending switch when idle; end the pulse when the counter expires
  always_comb begin
    pend = sw ^ sw_q;
    sel = pend[0] ? 3'b001 : pend[1] ? 3'b010 : 3'b100;
    start = state == IDLE && pend != '0;
    fin = state == PULSE && pcnt == '0;
    state_d = start ? PULSE : fin ? IDLE : state;
  end
  // shadow register, pulse counter and registered coil drives
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_q <= '0;
      pcnt <= '0;
      sw_norm <= '0;
      sw_div <= '0;
      sw_busy <= 1'b0;
    end else if (start) begin
      sw_q <= sw_q ^ sel;
      sw_div <= (sw & sel) != '0 ? sel : '0;
      sw_norm <= (sw & sel) != '0 ? '0 : sel;
      sw_busy <= 1'b1;
      pcnt <= PW'(PULSE_LEN - 1);
    end else if (fin) begin
      sw_norm <= '0;
      sw_div <= '0;
      sw_busy <= 1'b0;
    end else if (state == PULSE) pcnt <= pcnt - PW'(1);
endmodule

// File: tb/tb_train_drive.sv
// tb_train_drive: directed plus randomized checks of train_drive against a cycle model built from the behavioural rules.
module tb_train_drive;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dira, dirb;
  logic [2:0] sw;
  logic pwma, pwmb, fwda, fwdb, sw_busy;
  logic [2:0] sw_norm, sw_div;
  int checks = 0, errors = 0;
  int duty [2], fwd [2], pe [2];
  int cyc, cnt, rem;
  logic [2:0] q, ne, de;
  logic [1:0] pf;
  int h, n0, n2, n1;
  always #5 clk = ~clk;
  train_drive #(.PWM_BITS(4), .MAX_DUTY(8), .RAMP_DIV(4), .PULSE_LEN(5)) dut (
    .clk(clk), .rst(rst), .dira(dira), .dirb(dirb), .sw(sw),
    .pwma(pwma), .pwmb(pwmb), .fwda(fwda), .fwdb(fwdb),
    .sw_norm(sw_norm), .sw_div(sw_div), .sw_busy(sw_busy)
  );
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    duty = '{0, 0}; fwd = '{1, 1}; pe = '{0, 0};
    cyc = 0; cnt = 0; rem = 0; q = '0; ne = '0; de = '0;
  endtask
  task automatic model_step();
    int cmd [2];
    int tgt, lo;
    bit tick, mv, brk;
    logic [2:0] p;
    cmd[0] = int'(dira); cmd[1] = int'(dirb);
    for (int k = 0; k < 2; k++) pe[k] = (cnt < duty[k]) ? 1 : 0;
    tick = (cyc % 4) == 3;
    cyc++;
    cnt = (cnt + 1) % 16;
    for (int k = 0; k < 2; k++) begin
      brk = 0;
`ifdef TRAIN_DRIVE_BRAKE_EN
      brk = cmd[k] == 3;
`endif
      mv = cmd[k] == 1 || cmd[k] == 2;
      if (brk) duty[k] = 0;
      else if (tick) begin
        if (mv && (cmd[k] == 1 ? 1 : 0) != fwd[k]) begin
          if (duty[k] > 0) duty[k]--;
          else fwd[k] = cmd[k] == 1 ? 1 : 0;
        end else begin
          tgt = mv ? 8 : 0;
          if (duty[k] < tgt) duty[k]++;
          else if (duty[k] > tgt) duty[k]--;
        end
      end
    end
    p = sw ^ q;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin ne = '0; de = '0; end
    end else if (p != '0) begin
      lo = 0;
      for (int k = 2; k >= 0; k--) if (p[k]) lo = k;
      q[lo] = sw[lo];
      if (sw[lo]) de = 3'(1 << lo);
      else ne = 3'(1 << lo);
      rem = 5;
    end
  endtask
  task automatic cycle();
    pf = {fwdb, fwda};
    @(posedge clk);
    model_step();
    #1;
    check("pwma", pwma, pe[0]);
    check("pwmb", pwmb, pe[1]);
    check("fwda", fwda, fwd[0]);
    check("fwdb", fwdb, fwd[1]);
    check("sw_norm", sw_norm, ne);
    check("sw_div", sw_div, de);
    check("sw_busy", sw_busy, (ne | de) != '0);
    check("coil_excl", $countones({sw_norm, sw_div}) <= 1, 1);
    if (fwda !== pf[0]) check("pol_a_pwm", pwma, 0);
    if (fwdb !== pf[1]) check("pol_b_pwm", pwmb, 0);
  endtask
  task automatic run(int n);
    repeat (n) cycle();
  endtask
  initial begin
    rst = 1'b1; dira = 2'b00; dirb = 2'b00; sw = 3'b000;
    model_reset();
    #12;
    check("rst_pwma", pwma, 0); check("rst_pwmb", pwmb, 0);
    check("rst_fwda", fwda, 1); check("rst_fwdb", fwdb, 1);
    check("rst_norm", sw_norm, 0); check("rst_div", sw_div, 0); check("rst_busy", sw_busy, 0);
    @(negedge clk); rst = 1'b0;
    cycle();
    dira = 2'b01;
    run(40);
    h = 0;
    repeat (16) begin cycle(); h += int'(pwma); end
    check("cruise_fwd_hi", h, 8);
    check("cruise_fwda", fwda, 1);
    dira = 2'b10;
    run(100);
    check("rev_fwda", fwda, 0);
    h = 0;
    repeat (16) begin cycle(); h += int'(pwma); end
    check("cruise_rev_hi", h, 8);
    dira = 2'b11;
    run(40);
    h = 0;
    repeat (16) begin cycle(); h += int'(pwma); end
    check("stopped_hi", h, 0);
    check("brake_fwda", fwda, 0);
    sw = 3'b101;
    n0 = 0; n2 = 0;
    repeat (20) begin cycle(); n0 += int'(sw_div[0]); n2 += int'(sw_div[2]); end
    check("div0_len", n0, 5);
    check("div2_len", n2, 5);
    sw = 3'b100;
    run(2);
    sw = 3'b110;
    cycle();
    sw = 3'b100;
    n0 = 0; n1 = 0;
    repeat (15) begin cycle(); n0 += int'(sw_norm[0]); n1 += int'(sw_div[1]) + int'(sw_norm[1]); end
    check("norm0_len", n0, 2);
    check("sw1_glitch", n1, 0);
    dira = 2'b01; dirb = 2'b10;
    run(10);
    sw = 3'b011;
    run(3);
    #2 rst = 1'b1;
    #1;
    check("arst_pwma", pwma, 0); check("arst_pwmb", pwmb, 0);
    check("arst_fwda", fwda, 1); check("arst_fwdb", fwdb, 1);
    check("arst_norm", sw_norm, 0); check("arst_div", sw_div, 0); check("arst_busy", sw_busy, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) dira = 2'($urandom);
      if ($urandom_range(49) == 0) dirb = 2'($urandom);
      if ($urandom_range(9) == 0) sw = 3'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/train_drive.md
# train_drive

Output stage placed directly downstream of the train-control state machine. It turns the per-train direction commands (`dira`, `dirb`) into ramped PWM motor drive plus direction lines. It turns switch-position levels (`sw`) into timed, one-at-a-time solenoid pulses for twin-coil track switches. Motors never see a step change in speed or direction, and two switch coils are never energised together.

## Interface
Parameters:
- `PWM_BITS`, 8: width of the PWM counter and the duty registers.
- `MAX_DUTY`, 200: cruise duty. Must be ≤ 2^PWM_BITS−1.
- `RAMP_DIV`, 16: clk cycles per ramp tick. Must be ≥ 1.
- `PULSE_LEN`, 1000: solenoid pulse length in clk cycles. Must be ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `dira`, in, 2: train A command. 00 = stop, 01 = forward, 10 = reverse, 11 = brake.
- `dirb`, in, 2: train B command, same encoding as `dira`.
- `sw`, in, 3: requested switch positions. 0 = normal, 1 = diverge.
- `pwma`, out, 1: train A motor PWM.
- `pwmb`, out, 1: train B motor PWM.
- `fwda`, out, 1: train A polarity. 1 = forward.
- `fwdb`, out, 1: train B polarity. 1 = forward.
- `sw_norm`, out, 3: normal-coil pulse, one bit per switch.
- `sw_div`, out, 3: diverge-coil pulse, one bit per switch.
- `sw_busy`, out, 1: high while any coil pulse is active.

## Operation
- **Reset values:** all outputs 0, except `fwda` = `fwdb` = 1. Internal state: duty registers 0, PWM and ramp counters 0, switch shadow register `sw_q` = 000, pulse engine idle. Reset mid-ramp or mid-pulse drops everything immediately.
- **Target per channel:** command 01 or 10 → target = `MAX_DUTY`. Command 00 → target = 0. Command 11 → see Configuration.
- **Ramp tick:** a single prescaler, shared by both channels, raises a tick every `RAMP_DIV` cycles. On each tick, each channel takes at most one step.
  - If the requested direction differs from `fwd` and duty > 0: duty −1.
  - If the requested direction differs from `fwd` and duty = 0: `fwd` takes the requested direction. No duty change on this tick.
  - Otherwise: duty moves 1 toward target, saturating at target.
  - Commands 00 and 11 never change `fwd`.
- **Polarity:** `fwd` changes only while duty = 0. This is a hard invariant.
- **PWM:** one free-running `PWM_BITS` counter, shared. `pwmX` = (cnt < dutyX), registered. Duty 0 gives constant 0.
- **Switch engine:** a switch is pending when `sw[i]` ≠ `sw_q[i]`.
  - When the engine is idle and any switch is pending, it picks the lowest pending index i.
  - It sets `sw_q[i]` = `sw[i]` and starts a pulse: `sw_div[i]` if the new value is 1, otherwise `sw_norm[i]`.
- **Request changes:** a request that changes and returns before being serviced produces no pulse. A change to a switch that is already pulsing is queued as a new pending request.
- **Coil exclusivity:** at most one bit of {`sw_norm`, `sw_div`} is high at any time.

## Timing
- Command change to first duty step: ≤ `RAMP_DIV` cycles, aligned to the prescaler.
- Full ramp 0 → `MAX_DUTY`: `MAX_DUTY` ticks. A direction reversal at cruise takes 2·`MAX_DUTY` + 1 ticks.
- PWM period: 2^`PWM_BITS` cycles. A new duty value takes effect on the next cycle's compare.
- Pulse start: coil output goes high on the clock edge after the edge where `sw` ≠ `sw_q` is first sampled with the engine idle.
- Pulse length: high for exactly `PULSE_LEN` cycles. `sw_busy` is high for the same cycles.
- Gap: at least 1 cycle with all coils low between consecutive pulses.

## Configuration
Macro `TRAIN_DRIVE_BRAKE_EN`:
- Defined: command 11 forces that channel's duty to 0 on the next clock edge, bypassing the ramp. `fwd` is unchanged.
- Undefined: command 11 behaves exactly as 00, i.e. ramps down to 0.

## Test plan
All scenarios use `PWM_BITS`=4, `MAX_DUTY`=8, `RAMP_DIV`=4, `PULSE_LEN`=5.
- Reset release, then `dira`=01 → duty A reaches 8 after 8 ticks (≤ 36 cycles); `pwma` high 8 of every 16 cycles; `fwda`=1 throughout.
- Channel A at duty 8, then `dira`=10 → duty falls 8→0 over 8 ticks; `fwda`→0 on the next tick only; then ramps to 8. `pwma` is 0 at every cycle where `fwda` changes.
- Channel A at duty 8, then `dira`=11 → with `TRAIN_DRIVE_BRAKE_EN`, duty = 0 one cycle later; without it, 8 ticks of ramp-down.
- Engine idle, then `sw` 000→101 in one cycle → `sw_div[0]` high for 5 cycles; at least 1 idle cycle; `sw_div[2]` high for 5 cycles; `sw_busy` tracks both pulses; no coil overlap.
- During a pulse on switch 0, `sw[1]` goes 0→1→0 before the engine is idle → no pulse on switch 1.
- `rst` asserted mid-ramp and mid-pulse → all coil outputs, `pwma`, `pwmb` and duties are 0 immediately; `fwda`=`fwdb`=1.
